// File: rtl/inst_cache_pkg.sv
// inst_cache_pkg: bus width, cache geometry and IO-region decode shared with the memory arbiter
package inst_cache_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int ICACHE_INDEX_WIDTH = 6;
  function automatic logic is_io(input logic [DATA_WIDTH-1:0] addr);
    return addr[17:16] == 2'b11;
  endfunction
endpackage

// File: rtl/icache_array.sv
// icache_array: direct-mapped valid/tag/data storage, one async read port, one write port
module icache_array
  import inst_cache_pkg::*;
#(
  parameter int INDEX_WIDTH = ICACHE_INDEX_WIDTH,
  parameter int TAG_WIDTH = 30 - INDEX_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INDEX_WIDTH-1:0] rd_idx,
  output logic                   rd_valid,
  output logic [TAG_WIDTH-1:0]   rd_tag,
  output logic [DATA_WIDTH-1:0]  rd_data,
  input  logic                   we,
  input  logic [INDEX_WIDTH-1:0] wr_idx,
  input  logic [TAG_WIDTH-1:0]   wr_tag,
  input  logic [DATA_WIDTH-1:0]  wr_data
);
  logic [(1<<INDEX_WIDTH)-1:0] valid;
  logic [TAG_WIDTH-1:0] tags [1<<INDEX_WIDTH];
  logic [DATA_WIDTH-1:0] words [1<<INDEX_WIDTH];
  always_ff @(posedge clk or posedge rst)
    if (rst) valid <= '0;
    else if (we) valid[wr_idx] <= 1'b1;
  always_ff @(posedge clk)
    if (we) begin
      tags[wr_idx] <= wr_tag;
      words[wr_idx] <= wr_data;
    end
  assign rd_valid = valid[rd_idx];
  assign rd_tag = tags[rd_idx];
  assign rd_data = words[rd_idx];
endmodule

// File: rtl/inst_cache.sv
// inst_cache: direct-mapped single-outstanding instruction cache between fetcher and memory arbiter
module inst_cache
  import inst_cache_pkg::*;
#(
  parameter int INDEX_WIDTH = ICACHE_INDEX_WIDTH,
  parameter int TAG_WIDTH = 30 - INDEX_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic                  in_clear,
  input  logic                  in_fetcher_ena,
  input  logic [DATA_WIDTH-1:0] in_fetcher_addr,
  output logic                  out_fetcher_ok,
  output logic [DATA_WIDTH-1:0] out_fetcher_data,
  output logic                  out_mem_ena,
  output logic [DATA_WIDTH-1:0] out_mem_addr,
  input  logic                  in_mem_ok,
  input  logic [DATA_WIDTH-1:0] in_mem_data
);
  typedef enum logic [1:0] {IDLE, MISS, RESP} state_t;
  state_t state, state_n;
  logic ok_n, mem_ena_n, we, rd_valid, hit, req;
  logic [DATA_WIDTH-1:0] data_n, addr_n, rd_data;
  logic [TAG_WIDTH-1:0] rd_tag;
  icache_array #(.INDEX_WIDTH(INDEX_WIDTH), .TAG_WIDTH(TAG_WIDTH)) u_array (
    .clk(clk),
    .rst(rst),
    .rd_idx(in_fetcher_addr[INDEX_WIDTH+1:2]),
    .rd_valid(rd_valid),
    .rd_tag(rd_tag),
    .rd_data(rd_data),
    .we(we),
    .wr_idx(out_mem_addr[INDEX_WIDTH+1:2]),
    .wr_tag(out_mem_addr[31:INDEX_WIDTH+2]),
    .wr_data(in_mem_data)
  );
  assign hit = rd_valid && rd_tag == in_fetcher_addr[31:INDEX_WIDTH+2];
  assign req = in_fetcher_ena && !out_fetcher_ok;
  assign we = ena && !in_clear && state == MISS && in_mem_ok && !is_io(out_mem_addr);
  always_comb begin
    state_n = state;
    ok_n = 1'b0;
    data_n = out_fetcher_data;
    mem_ena_n = out_mem_ena;
    addr_n = out_mem_addr;
    if (in_clear) begin
      state_n = IDLE;
      mem_ena_n = 1'b0;
    end else if (state == IDLE && req && hit) begin
      ok_n = 1'b1;
      data_n = rd_data;
    end else if (state == IDLE && req) begin
      state_n = MISS;
      mem_ena_n = 1'b1;
      addr_n = in_fetcher_addr & ~32'h3;
    end else if (state == MISS && in_mem_ok) begin
      state_n = RESP;
      mem_ena_n = 1'b0;
      ok_n = 1'b1;
      data_n = in_mem_data;
    end else if (state == RESP) begin
      state_n = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      out_fetcher_ok <= 1'b0;
      out_fetcher_data <= '0;
      out_mem_ena <= 1'b0;
      out_mem_addr <= '0;
    end else if (ena) begin
      state <= state_n;
      out_fetcher_ok <= ok_n;
      out_fetcher_data <= data_n;
      out_mem_ena <= mem_ena_n;
      out_mem_addr <= addr_n;
    end
endmodule
